// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Handshake and data bundle between decode, the ALU issue stage and the
//   ALU / result consumer.
//   slave  : the issue stage (consumes upstream request, drives ALU inputs)
//   master : the environment (upstream decode + downstream consumer)
//   Upstream   : flush, in_valid, in_ready, in_alu_control, in_a, in_b,
//                fwd_a_sel, fwd_b_sel, ex_mem_result, mem_wb_result
//   Downstream : alu_control, op_a, op_b, out_valid, out_ready, busy
interface alu_issue_stage_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_control;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [WIDTH-1:0] ex_mem_result;
    logic [WIDTH-1:0] mem_wb_result;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  flush, in_valid, in_alu_control, in_a, in_b,
               fwd_a_sel, fwd_b_sel, ex_mem_result, mem_wb_result, out_ready,
        output in_ready, alu_control, op_a, op_b, out_valid, busy
    );

    modport master (
        output flush, in_valid, in_alu_control, in_a, in_b,
               fwd_a_sel, fwd_b_sel, ex_mem_result, mem_wb_result, out_ready,
        input  in_ready, alu_control, op_a, op_b, out_valid, busy
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Registered issue stage in front of the 32-bit ALU. Selects each operand
//   from the register file or one of two forwarding paths, captures opcode
//   and operands on accept and keeps them stable until the next accept so the
//   ALU can be timed as a multicycle path for div (0000) and mul (0001).
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - alu_issue_stage_if.slave (request, forwarding, ALU drive,
//            result valid/ready, busy)
//   Parameters:
//     WIDTH         - operand width
//     MULDIV_CYCLES - accept-to-valid latency for div/mul (1..15)
module alu_issue_stage #(
    parameter int WIDTH         = 32,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Counter value loaded on accept; the accept edge itself is the first
    // of the MULDIV_CYCLES edges.
    localparam logic [3:0] MD_RELOAD = 4'(MULDIV_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic             in_ready;
    logic             accept;
    logic             is_muldiv;

    // Operand forwarding; select 11 falls back to the register file.
    always_comb begin
        fwd_a = bus.in_a;
        case (bus.fwd_a_sel)
            2'b01:   fwd_a = bus.ex_mem_result;
            2'b10:   fwd_a = bus.mem_wb_result;
            default: fwd_a = bus.in_a;
        endcase
    end

    always_comb begin
        fwd_b = bus.in_b;
        case (bus.fwd_b_sel)
            2'b01:   fwd_b = bus.ex_mem_result;
            2'b10:   fwd_b = bus.mem_wb_result;
            default: fwd_b = bus.in_b;
        endcase
    end

    // FULL only takes a new op when the current result is consumed in the
    // same cycle, giving bubble-free replacement.
    assign in_ready  = !bus.flush &&
                       ((state_q == S_EMPTY) ||
                        ((state_q == S_FULL) && bus.out_ready));
    assign accept    = bus.in_valid && in_ready;
    assign is_muldiv = (bus.in_alu_control[3:1] == 3'b000) && (MULDIV_CYCLES > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            cnt_q       <= 4'd0;
            ctrl_q      <= 4'hF;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.flush) begin
            // Kill the held op but leave the operand registers alone.
            state_q     <= S_EMPTY;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            ctrl_q <= bus.in_alu_control;
            a_q    <= fwd_a;
            b_q    <= fwd_b;
            if (is_muldiv) begin
                state_q     <= S_WAIT;
                cnt_q       <= MD_RELOAD;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                state_q     <= S_FULL;
                cnt_q       <= 4'd0;
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_FULL;
                        cnt_q       <= 4'd0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FULL: begin
                    if (bus.out_ready) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.alu_control = ctrl_q;
    assign bus.op_a        = a_q;
    assign bus.op_b        = b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    logic clk;
    logic rst;

    alu_issue_stage_if #(.WIDTH(32)) bus ();

    alu_issue_stage #(.WIDTH(32), .MULDIV_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errs    = 0;

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] ex, input logic [31:0] wb);
        case (sel)
            2'b01:   return ex;
            2'b10:   return wb;
            default: return rf;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready against the bench's expectation, retire a
    // consumed result against the scoreboard, record an accepted request.
    task automatic cycle(input logic exp_rdy);
        exp_t e;
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ctrl", {28'd0, bus.alu_control}, {28'd0, e.c});
                chk("sb_op_a", bus.op_a, e.a);
                chk("sb_op_b", bus.op_b, e.b);
            end
        end
        if (bus.in_valid && exp_rdy && !bus.flush) begin
            e.c = bus.in_alu_control;
            e.a = fwd(bus.fwd_a_sel, bus.in_a, bus.ex_mem_result, bus.mem_wb_result);
            e.b = fwd(bus.fwd_b_sel, bus.in_b, bus.ex_mem_result, bus.mem_wb_result);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid       = 1'b1;
        bus.in_alu_control = c;
        bus.in_a           = a;
        bus.in_b           = b;
    endtask

    initial begin
        rst                = 1'b1;
        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_alu_control = 4'd0;
        bus.in_a           = '0;
        bus.in_b           = '0;
        bus.fwd_a_sel      = 2'b00;
        bus.fwd_b_sel      = 2'b00;
        bus.ex_mem_result  = '0;
        bus.mem_wb_result  = '0;
        bus.out_ready      = 1'b1;

        // Reset values
        #3;
        chk("rst_ctrl", {28'd0, bus.alu_control}, 32'hF);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_op_b", bus.op_b, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add then back-to-back sub with no bubble
        drive(4'b0011, 32'd5, 32'd7);
        cycle(1'b1);
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_op_a", bus.op_a, 32'd5);
        chk("add_op_b", bus.op_b, 32'd7);
        drive(4'b0010, 32'd9, 32'd4);
        cycle(1'b1);
        chk("sub_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("sub_op_a", bus.op_a, 32'd9);
        bus.in_valid = 1'b0;
        cycle(1'b1);
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // div: three WAIT cycles with a competing request held off
        drive(4'b0000, 32'd100, 32'd7);
        cycle(1'b1);
        drive(4'b0011, 32'hBAD, 32'hBAD);
        for (int i = 0; i < 3; i++) begin
            chk("div_busy", {31'd0, bus.busy}, 32'd1);
            chk("div_valid_lo", {31'd0, bus.out_valid}, 32'd0);
            chk("div_op_a_hold", bus.op_a, 32'd100);
            chk("div_op_b_hold", bus.op_b, 32'd7);
            cycle(1'b0);
        end
        chk("div_valid_hi", {31'd0, bus.out_valid}, 32'd1);
        chk("div_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("div_ctrl", {28'd0, bus.alu_control}, 32'd0);
        bus.in_valid = 1'b0;
        cycle(1'b1);

        // Forwarding paths, then select 11 with an undefined opcode
        drive(4'b0100, 32'd1, 32'd2);
        bus.fwd_a_sel     = 2'b01;
        bus.fwd_b_sel     = 2'b10;
        bus.ex_mem_result = 32'hDEAD;
        bus.mem_wb_result = 32'h1234;
        cycle(1'b1);
        chk("fwd_op_a", bus.op_a, 32'hDEAD);
        chk("fwd_op_b", bus.op_b, 32'h1234);
        drive(4'b1110, 32'h55, 32'h66);
        bus.fwd_a_sel = 2'b11;
        bus.fwd_b_sel = 2'b11;
        cycle(1'b1);
        chk("fwd11_op_a", bus.op_a, 32'h55);
        chk("fwd11_op_b", bus.op_b, 32'h66);
        chk("undef_valid", {31'd0, bus.out_valid}, 32'd1);

        // Downstream stall: everything frozen for 5 cycles
        bus.fwd_a_sel = 2'b00;
        bus.fwd_b_sel = 2'b00;
        bus.out_ready = 1'b0;
        drive(4'b0101, 32'h77, 32'h88);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            chk("stall_op_a", bus.op_a, 32'h55);
            chk("stall_ctrl", {28'd0, bus.alu_control}, 32'hE);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        cycle(1'b1);
        chk("unstall_op_a", bus.op_a, 32'h77);
        bus.in_valid = 1'b0;
        cycle(1'b1);

        // mul flushed mid-WAIT at count 2; the op is lost
        drive(4'b0001, 32'd3, 32'd4);
        cycle(1'b1);
        void'(sb.pop_back());
        bus.in_valid = 1'b0;
        cycle(1'b0);
        bus.flush = 1'b1;
        cycle(1'b0);
        bus.flush = 1'b0;
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_keep_a", bus.op_a, 32'd3);

        // flush in EMPTY with a request present: nothing captured
        bus.flush = 1'b1;
        drive(4'b0011, 32'h99, 32'h98);
        cycle(1'b0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_nocap_a", bus.op_a, 32'd3);
        chk("flush_nocap_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-WAIT: immediate clear, op lost
        drive(4'b0000, 32'd11, 32'd12);
        cycle(1'b1);
        void'(sb.pop_back());
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_ctrl", {28'd0, bus.alu_control}, 32'hF);
        chk("rstw_op_a", bus.op_a, 32'd0);
        chk("rstw_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstw_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery after reset
        drive(4'b0011, 32'd1, 32'd2);
        cycle(1'b1);
        bus.in_valid = 1'b0;
        cycle(1'b1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
